// File: rtl/run_result_tx.sv
// Run controller and result transmitter: releases the CPU on start, times the run, then streams
// HDR, status, count[31:0] (MSB first), ret byte (+ XOR checksum when RUN_RESULT_CHECKSUM_EN is defined).
module run_result_tx #(
  parameter logic [63:0] MAX_CYCLES = 64'd500000,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        isHalt,
  input  logic [15:0] ret_val,
  output logic        cpu_run,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);
`ifdef RUN_RESULT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
`else
  localparam logic [2:0] LAST_IDX = 3'd6;
`endif

  typedef enum logic [1:0] {IDLE, RUN, SEND} state_t;
  typedef struct packed {
    logic [7:0]  status;
    logic [31:0] cnt;
    logic [7:0]  ret;
  } result_t;

  state_t      state, state_nxt;
  logic [31:0] count;
  result_t     lat;
  logic [2:0]  idx, idx_n;
  logic        halt_hit, tmo_hit, tx_fire, last_byte;
  logic [7:0]  nxt_byte;
  logic        unused_ret_hi;

  assign unused_ret_hi = ^ret_val[15:8];
  assign cpu_run   = (state == RUN);
  assign busy      = (state != IDLE);
  assign tx_fire   = tx_valid && tx_ready;
  assign last_byte = (idx == LAST_IDX);
  assign idx_n     = idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Count is zero-extended so an oversized MAX_CYCLES simply never matches.
  always_comb begin
    state_nxt = state;
    halt_hit  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        halt_hit = isHalt;
        tmo_hit  = !isHalt && ({32'd0, count} == MAX_CYCLES);
        if (halt_hit || tmo_hit) state_nxt = SEND;
      end
      SEND: if (tx_fire && last_byte) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte presented after the current one is accepted.
  always_comb begin
    nxt_byte = HDR_BYTE;
    case (idx_n)
      3'd1: nxt_byte = lat.status;
      3'd2: nxt_byte = lat.cnt[31:24];
      3'd3: nxt_byte = lat.cnt[23:16];
      3'd4: nxt_byte = lat.cnt[15:8];
      3'd5: nxt_byte = lat.cnt[7:0];
      3'd6: nxt_byte = lat.ret;
`ifdef RUN_RESULT_CHECKSUM_EN
      3'd7: nxt_byte = lat.status ^ lat.cnt[31:24] ^ lat.cnt[23:16] ^
                       lat.cnt[15:8] ^ lat.cnt[7:0] ^ lat.ret;
`endif
      default: nxt_byte = HDR_BYTE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      lat      <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) count <= '0;
        RUN: begin
          count <= count + 32'd1;
          if (halt_hit || tmo_hit) begin
            lat.status <= halt_hit ? 8'h01 : 8'h02;
            lat.cnt    <= count;
            lat.ret    <= ret_val[7:0];
            idx        <= '0;
            tx_valid   <= 1'b1;
            tx_data    <= HDR_BYTE;
          end
        end
        SEND: if (tx_fire) begin
          if (last_byte) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
          end else begin
            idx     <= idx_n;
            tx_data <= nxt_byte;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_run_result_tx.sv
// Directed bench for run_result_tx (MAX_CYCLES=20); packet length follows RUN_RESULT_CHECKSUM_EN.
module tb_run_result_tx;
`ifdef RUN_RESULT_CHECKSUM_EN
  localparam int PKT = 8;
`else
  localparam int PKT = 7;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, isHalt = 1'b0, tx_ready = 1'b0;
  logic [15:0] ret_val = '0;
  logic        cpu_run, tx_valid, busy, done;
  logic [7:0]  tx_data;
  logic [7:0]  e [8];
  int          n_chk = 0, n_err = 0;

  run_result_tx #(.MAX_CYCLES(64'd20), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .isHalt(isHalt), .ret_val(ret_val),
    .cpu_run(cpu_run), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Start a run, halt when count==halt_at (-1: never), poke start mid-run.
  task automatic do_run(input int halt_at, input logic [15:0] ret, input int exp_runs);
    int cyc;
    ret_val = ret; start = 1'b1; step(); start = 1'b0;
    chk("run_entry", {31'd0, cpu_run}, 32'd1);
    cyc = 0;
    while (cpu_run && cyc < 200) begin
      isHalt = (cyc == halt_at);
      start  = (cyc == 3);
      cyc++;
      step();
    end
    isHalt = 1'b0; start = 1'b0;
    chk("run_cycles", cyc, exp_runs);
  endtask

  // Drain the packet; optional stall on one byte, optional reset when abort_at is presented.
  task automatic do_send(input int stall_idx, input int stall_len, input int abort_at);
    int n, g, st;
    bit aborted;
    n = 0; g = 0; st = 0; aborted = 0;
    while (n < PKT && g < 100 && !aborted) begin
      chk("send_valid", {31'd0, tx_valid}, 32'd1);
      if (n == abort_at) begin
        chk("abort_byte", tx_data, e[n]);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_run", {31'd0, cpu_run}, 32'd0);
        chk("abort_data", tx_data, 32'd0);
        step(); rst_n = 1'b1; tx_ready = 1'b0;
        step();
        chk("abort_idle", {31'd0, busy}, 32'd0);
        aborted = 1;
      end else begin
        if (n == stall_idx && st < stall_len) begin
          tx_ready = 1'b0; st++;
          chk("stall_hold", tx_data, e[n]);
        end else begin
          tx_ready = 1'b1;
          chk($sformatf("byte%0d", n), tx_data, e[n]);
          n++;
        end
        start = (n == 2);
        step();
        g++;
      end
    end
    tx_ready = 1'b0; start = 1'b0;
    if (!aborted) begin
      chk("no_bubble", g, PKT + st);
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("end_valid", {31'd0, tx_valid}, 32'd0);
      chk("end_busy", {31'd0, busy}, 32'd0);
      step();
      chk("done_once", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    step(); step();
    chk("rst_run", {31'd0, cpu_run}, 32'd0);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", tx_data, 32'd0);
    rst_n = 1'b1; step();

    isHalt = 1'b1; step(); step();
    chk("idle_halt", {31'd0, busy}, 32'd0);
    isHalt = 1'b0;

    // Halt at count 10
    e = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h2A, 8'h21};
    do_run(10, 16'h122A, 11); do_send(-1, 0, -1);

    // Timeout at 20
    e = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h14, 8'h07, 8'h11};
    do_run(-1, 16'h0007, 21); do_send(-1, 0, -1);

    // Halt coincides with timeout: halt wins
    e = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h14, 8'h33, 8'h26};
    do_run(20, 16'h0033, 21); do_send(-1, 0, -1);

    // Back-pressure on idx3 for 3 cycles
    e = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 8'h80, 8'h84};
    do_run(5, 16'hFF80, 6); do_send(3, 3, -1);

    // Reset while idx4 is presented
    e = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02};
    do_run(2, 16'h0001, 3); do_send(-1, 0, 4);

    // Reset during RUN
    start = 1'b1; step(); start = 1'b0; step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("runrst_run", {31'd0, cpu_run}, 32'd0);
    chk("runrst_busy", {31'd0, busy}, 32'd0);
    step(); rst_n = 1'b1; step();
    chk("runrst_idle", {31'd0, busy}, 32'd0);

    // Fresh packet after aborts
    e = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07, 8'h34, 8'h32};
    do_run(7, 16'h1234, 8); do_send(-1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
